// File: rtl/bist_pattern_gen.sv
// bist_pattern_gen: LFSR stimulus generator that issues a counted run of patterns, then flushes and reports done.
module bist_pattern_gen #(
    parameter int               WIDTH        = 22,
    parameter logic [WIDTH-1:0] SEED         = 22'h000001,
    parameter int               CNT_W        = 16,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic             hold,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pat_count
);
    localparam int FW = $clog2(FLUSH_CYCLES + 2);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    localparam state_t END_ST = (FLUSH_CYCLES == 0) ? DONE : FLUSH;
    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_lfsr, w_lfsr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_num, w_num_nxt;
    logic [FW-1:0]    r_flush, w_flush_nxt;
    logic             w_issue;
    assign w_issue       = (r_state == RUN) && !hold;
    assign pattern       = r_lfsr;
    assign pattern_valid = w_issue;
    assign busy          = (r_state == RUN) || (r_state == FLUSH);
    assign done          = (r_state == DONE);
    assign pat_count     = r_cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_lfsr  <= SEED;
            r_cnt   <= '0;
            r_num   <= '0;
            r_flush <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_num   <= w_num_nxt;
            r_flush <= w_flush_nxt;
        end
    end
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_cnt_nxt   = r_cnt;
        w_num_nxt   = r_num;
        w_flush_nxt = r_flush;
        case (r_state)
            IDLE, DONE: if (start) begin
                w_lfsr_nxt  = SEED;
                w_cnt_nxt   = '0;
                w_num_nxt   = num_pat;
                w_flush_nxt = '0;
                w_state_nxt = (num_pat != '0) ? RUN : END_ST;
            end
            RUN: if (w_issue) begin
                w_lfsr_nxt  = {r_lfsr[WIDTH-2:0], r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-2]};
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                w_flush_nxt = '0;
                w_state_nxt = (r_cnt == r_num - CNT_W'(1)) ? END_ST : RUN;
            end
            FLUSH: begin
                w_flush_nxt = r_flush + FW'(1);
                w_state_nxt = (r_flush == FW'(FLUSH_CYCLES - 1)) ? DONE : FLUSH;
            end
            default: w_state_nxt = IDLE;
        endcase
    end
endmodule
